pipe_ctrl_unit: RTL and testbench

Pipelined successor to the single-cycle decode control unit. It decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble), squashes on a taken branch, and generates EX-stage forwarding selects. It sits between the IF/ID register and the datapath stage registers of the 5-stage RISC-V pipeline.

---
 rtl/pipe_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined decode/control: ID decode, ID/EX-EX/MEM-MEM/WB control pipe, load-use stall, flush, forwarding.
// Optional PIPE_CTRL_JUMP_EN enables jal/jalr/lui/auipc decode; otherwise they are illegal and ex_jump is 0.
module pipe_ctrl_unit #(
    parameter int unsigned RF_ADDR_W = 5,
    parameter int unsigned OP_W      = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [OP_W-1:0]      id_op,
    input  logic [RF_ADDR_W-1:0] id_rs1,
    input  logic [RF_ADDR_W-1:0] id_rs2,
    input  logic [RF_ADDR_W-1:0] id_rd,
    input  logic                 ex_taken,
    output logic                 stall,
    output logic                 flush,
    output logic                 id_illegal,
    output logic                 illegal_seen,
    output logic [1:0]           ex_ALUop,
    output logic                 ex_ALUsrc,
    output logic                 ex_branch,
    output logic                 ex_jump,
    output logic [RF_ADDR_W-1:0] ex_rs1,
    output logic [RF_ADDR_W-1:0] ex_rs2,
    output logic [RF_ADDR_W-1:0] ex_rd,
    output logic                 mem_memread,
    output logic                 mem_memwrite,
    output logic                 mem_MtoR,
    output logic                 mem_regwrite,
    output logic [RF_ADDR_W-1:0] mem_rd,
    output logic                 wb_MtoR,
    output logic                 wb_regwrite,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b
);

    localparam logic [OP_W-1:0] OP_R     = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_B     = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_IMM   = OP_W'(7'b0010011);
`ifdef PIPE_CTRL_JUMP_EN
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(7'b1100111);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(7'b0110111);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(7'b0010111);
`endif

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mtor;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
    } ctrl_t;

    ctrl_t                dec;
    logic                 legal;
    logic                 uses_rs2;
    logic                 hz;
    logic                 id_bubble;

    ctrl_t                ex_ctrl;
    logic [RF_ADDR_W-1:0] ex_rs1_q;
    logic [RF_ADDR_W-1:0] ex_rs2_q;
    logic [RF_ADDR_W-1:0] ex_rd_q;

    logic                 mem_memread_q;
    logic                 mem_memwrite_q;
    logic                 mem_mtor_q;
    logic                 mem_regwrite_q;
    logic [RF_ADDR_W-1:0] mem_rd_q;

    logic                 wb_mtor_q;
    logic                 wb_regwrite_q;
    logic [RF_ADDR_W-1:0] wb_rd_q;

    logic                 illegal_seen_q;

    // Opcode decode; unknown opcodes fall through to an all-zero bundle
    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        uses_rs2 = 1'b0;
        case (id_op)
            OP_R: begin
                dec.alu_op   = 2'b10;
                dec.regwrite = 1'b1;
                legal        = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_B: begin
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
                legal      = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src  = 1'b1;
                dec.mtor     = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                legal        = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src  = 1'b1;
                dec.memwrite = 1'b1;
                legal        = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_IMM: begin
                dec.alu_op   = 2'b11;
                dec.alu_src  = 1'b1;
                dec.regwrite = 1'b1;
                legal        = 1'b1;
            end
`ifdef PIPE_CTRL_JUMP_EN
            OP_JAL, OP_JALR: begin
                dec.alu_src  = 1'b1;
                dec.regwrite = 1'b1;
                dec.jump     = 1'b1;
                legal        = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.alu_src  = 1'b1;
                dec.regwrite = 1'b1;
                legal        = 1'b1;
            end
`endif
            default: begin
                dec   = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Load-use hazard: rs2 only matters for opcodes that actually read it
    always_comb begin
        hz = id_valid && ex_ctrl.memread && (ex_rd_q != '0) &&
             ((ex_rd_q == id_rs1) || ((ex_rd_q == id_rs2) && uses_rs2));
    end

    assign stall      = hz && !ex_taken;
    assign flush      = ex_taken;
    assign id_illegal = id_valid && !legal;
    assign id_bubble  = stall || ex_taken || !id_valid || !legal;

    // ID/EX register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
        end else if (id_bubble) begin
            ex_ctrl  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_rd_q  <= '0;
        end else begin
            ex_ctrl  <= dec;
            ex_rs1_q <= id_rs1;
            ex_rs2_q <= id_rs2;
            ex_rd_q  <= id_rd;
        end
    end

    // EX/MEM register; branch/jump stop at EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_memread_q  <= 1'b0;
            mem_memwrite_q <= 1'b0;
            mem_mtor_q     <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
        end else begin
            mem_memread_q  <= ex_ctrl.memread;
            mem_memwrite_q <= ex_ctrl.memwrite;
            mem_mtor_q     <= ex_ctrl.mtor;
            mem_regwrite_q <= ex_ctrl.regwrite;
            mem_rd_q       <= ex_rd_q;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_mtor_q     <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
        end else begin
            wb_mtor_q     <= mem_mtor_q;
            wb_regwrite_q <= mem_regwrite_q;
            wb_rd_q       <= mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen_q <= 1'b0;
        end else if (id_illegal) begin
            illegal_seen_q <= 1'b1;
        end
    end

    // Forwarding select; the younger EX/MEM result has priority over MEM/WB
    function automatic logic [1:0] fwd_sel(
        input logic [RF_ADDR_W-1:0] rs,
        input logic                 m_rw,
        input logic [RF_ADDR_W-1:0] m_rd,
        input logic                 w_rw,
        input logic [RF_ADDR_W-1:0] w_rd
    );
        if (m_rw && (m_rd != '0) && (m_rd == rs)) begin
            return 2'b10;
        end else if (w_rw && (w_rd != '0) && (w_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1_q, mem_regwrite_q, mem_rd_q, wb_regwrite_q, wb_rd_q);
        fwd_b = fwd_sel(ex_rs2_q, mem_regwrite_q, mem_rd_q, wb_regwrite_q, wb_rd_q);
    end

    assign ex_ALUop     = ex_ctrl.alu_op;
    assign ex_ALUsrc    = ex_ctrl.alu_src;
    assign ex_branch    = ex_ctrl.branch;
    assign ex_jump      = ex_ctrl.jump;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign mem_memread  = mem_memread_q;
    assign mem_memwrite = mem_memwrite_q;
    assign mem_MtoR     = mem_mtor_q;
    assign mem_regwrite = mem_regwrite_q;
    assign mem_rd       = mem_rd_q;
    assign wb_MtoR      = wb_mtor_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign wb_rd        = wb_rd_q;
    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, pipe latency, load-use, flush, forwarding, illegal, reset.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_taken;
    logic       stall, flush, id_illegal, illegal_seen;
    logic [1:0] ex_ALUop;
    logic       ex_ALUsrc, ex_branch, ex_jump;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_memread, mem_memwrite, mem_MtoR, mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_MtoR, wb_regwrite;
    logic [4:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;

    int n_cmp;
    int n_bad;

    pipe_ctrl_unit #(.RF_ADDR_W(5), .OP_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_taken(ex_taken),
        .stall(stall), .flush(flush), .id_illegal(id_illegal), .illegal_seen(illegal_seen),
        .ex_ALUop(ex_ALUop), .ex_ALUsrc(ex_ALUsrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_MtoR(mem_MtoR),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .wb_MtoR(wb_MtoR), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic tk);
        id_valid = v;
        id_op    = op;
        id_rs1   = r1;
        id_rs2   = r2;
        id_rd    = rd;
        ex_taken = tk;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_ex_ALUop", 32'(ex_ALUop), 0);
        chk("rst_ex_rd", 32'(ex_rd), 0);
        chk("rst_mem_regwrite", 32'(mem_regwrite), 0);
        chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_a", 32'(fwd_a), 0);
        chk("rst_fwd_b", 32'(fwd_b), 0);
        chk("rst_illegal_seen", 32'(illegal_seen), 0);
        chk("rst_id_illegal", 32'(id_illegal), 0);
        rst_n = 1'b1;

        // First capture after release
        tick();
        chk("rel_ex_ALUop", 32'(ex_ALUop), 2);
        chk("rel_ex_rd", 32'(ex_rd), 3);
        chk("rel_ex_rs1", 32'(ex_rs1), 1);
        chk("rel_ex_rs2", 32'(ex_rs2), 2);
        chk("rel_ex_ALUsrc", 32'(ex_ALUsrc), 0);
        chk("rel_mem_regwrite", 32'(mem_regwrite), 0);

        // Forwarding: both stages target x3
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0); tick();
        drive(1'b1, OP_R, 5'd3, 5'd3, 5'd7, 1'b0); tick();
        chk("fwd_both_a", 32'(fwd_a), 2);
        chk("fwd_both_b", 32'(fwd_b), 2);
        chk("fwd_wb_regwrite", 32'(wb_regwrite), 1);
        chk("fwd_wb_rd", 32'(wb_rd), 3);
        chk("fwd_mem_rd", 32'(mem_rd), 3);

        // Forwarding: EX/MEM writes x0, MEM/WB writes x3
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd3, 1'b0); tick();
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        drive(1'b1, OP_R, 5'd3, 5'd0, 5'd9, 1'b0); tick();
        chk("fwd_wb_a", 32'(fwd_a), 1);
        chk("fwd_wb_b", 32'(fwd_b), 0);

        // Forwarding: x0 destinations never forward
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        chk("fwd_x0wb_a", 32'(fwd_a), 0);
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        chk("fwd_x0mem_a", 32'(fwd_a), 0);
        chk("fwd_x0mem_b", 32'(fwd_b), 0);

        // Load-use on rs1
        drive(1'b1, OP_L, 5'd1, 5'd0, 5'd5, 1'b0); tick();
        chk("lw_ex_ALUsrc", 32'(ex_ALUsrc), 1);
        chk("lw_ex_rd", 32'(ex_rd), 5);
        drive(1'b1, OP_R, 5'd5, 5'd6, 5'd8, 1'b0);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_flush", 32'(flush), 0);
        tick();
        chk("lu_bub_ex_rd", 32'(ex_rd), 0);
        chk("lu_bub_ex_ALUop", 32'(ex_ALUop), 0);
        chk("lu_bub_ex_rs1", 32'(ex_rs1), 0);
        chk("lu_stall_drop", 32'(stall), 0);
        chk("lu_mem_memread", 32'(mem_memread), 1);
        chk("lu_mem_MtoR", 32'(mem_MtoR), 1);
        chk("lu_mem_rd", 32'(mem_rd), 5);
        tick();
        chk("lu_ex_ALUop", 32'(ex_ALUop), 2);
        chk("lu_ex_rd", 32'(ex_rd), 8);
        chk("lu_wb_MtoR", 32'(wb_MtoR), 1);
        chk("lu_wb_rd", 32'(wb_rd), 5);
        chk("lu_fwd_a", 32'(fwd_a), 1);

        // Load-use on rs2 depends on opcode class
        drive(1'b1, OP_L, 5'd0, 5'd0, 5'd5, 1'b0); tick();
        drive(1'b1, OP_I, 5'd1, 5'd5, 5'd9, 1'b0);
        chk("rs2_addi_stall", 32'(stall), 0);
        drive(1'b1, OP_R, 5'd1, 5'd5, 5'd9, 1'b0);
        chk("rs2_r_stall", 32'(stall), 1);
        drive(1'b1, OP_S, 5'd1, 5'd5, 5'd0, 1'b0);
        chk("rs2_s_stall", 32'(stall), 1);
        drive(1'b1, OP_B, 5'd1, 5'd5, 5'd0, 1'b0);
        chk("rs2_b_stall", 32'(stall), 1);
        drive(1'b0, OP_R, 5'd5, 5'd5, 5'd9, 1'b0);
        chk("inv_stall", 32'(stall), 0);

        // Flush beats stall
        drive(1'b1, OP_R, 5'd5, 5'd0, 5'd8, 1'b1);
        chk("fl_stall", 32'(stall), 0);
        chk("fl_flush", 32'(flush), 1);
        tick();
        chk("fl_ex_rd", 32'(ex_rd), 0);
        chk("fl_ex_ALUop", 32'(ex_ALUop), 0);
        chk("fl_mem_regwrite", 32'(mem_regwrite), 1);
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("fl_after_flush", 32'(flush), 0);
        tick();
        chk("fl_bub_mem_regwrite", 32'(mem_regwrite), 0);
        chk("fl_bub_mem_rd", 32'(mem_rd), 0);

        // Branch, store, addi decodes
        drive(1'b1, OP_B, 5'd1, 5'd2, 5'd0, 1'b0); tick();
        chk("br_ex_branch", 32'(ex_branch), 1);
        chk("br_ex_ALUop", 32'(ex_ALUop), 1);
        chk("br_ex_ALUsrc", 32'(ex_ALUsrc), 0);
        drive(1'b1, OP_S, 5'd1, 5'd2, 5'd0, 1'b0); tick();
        chk("st_ex_ALUsrc", 32'(ex_ALUsrc), 1);
        chk("st_ex_branch", 32'(ex_branch), 0);
        chk("br_mem_regwrite", 32'(mem_regwrite), 0);
        chk("br_mem_memwrite", 32'(mem_memwrite), 0);
        drive(1'b1, OP_I, 5'd1, 5'd0, 5'd4, 1'b0); tick();
        chk("addi_ex_ALUop", 32'(ex_ALUop), 3);
        chk("st_mem_memwrite", 32'(mem_memwrite), 1);
        chk("st_mem_regwrite", 32'(mem_regwrite), 0);

        // Illegal opcode
        drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd6, 1'b0);
        chk("ill_id_illegal", 32'(id_illegal), 1);
        chk("ill_seen_pre", 32'(illegal_seen), 0);
        tick();
        chk("ill_seen", 32'(illegal_seen), 1);
        chk("ill_ex_ALUop", 32'(ex_ALUop), 0);
        chk("ill_ex_rd", 32'(ex_rd), 0);
        drive(1'b0, OP_BAD, 5'd1, 5'd2, 5'd6, 1'b0);
        chk("ill_invalid", 32'(id_illegal), 0);
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("ill_legal", 32'(id_illegal), 0);
        tick();
        chk("ill_seen_sticky", 32'(illegal_seen), 1);
        chk("ill_after_ALUop", 32'(ex_ALUop), 2);

        // jal: legal only with the jump feature compiled in
        drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd1, 1'b0);
`ifdef PIPE_CTRL_JUMP_EN
        chk("jal_id_illegal", 32'(id_illegal), 0);
        tick();
        chk("jal_ex_jump", 32'(ex_jump), 1);
        chk("jal_ex_rd", 32'(ex_rd), 1);
        chk("jal_ex_ALUsrc", 32'(ex_ALUsrc), 1);
`else
        chk("jal_id_illegal", 32'(id_illegal), 1);
        tick();
        chk("jal_ex_jump", 32'(ex_jump), 0);
        chk("jal_ex_rd", 32'(ex_rd), 0);
`endif

        // Reset mid-operation discards in-flight writes
        drive(1'b1, OP_S, 5'd1, 5'd2, 5'd0, 1'b0); tick();
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0); tick();
        chk("pre_rst_mem_memwrite", 32'(mem_memwrite), 1);
        tick();
        tick();
        chk("pre_rst_wb_regwrite", 32'(wb_regwrite), 1);
        chk("pre_rst_mem_regwrite", 32'(mem_regwrite), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_regwrite", 32'(mem_regwrite), 0);
        chk("mid_rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("mid_rst_mem_memwrite", 32'(mem_memwrite), 0);
        chk("mid_rst_ex_ALUop", 32'(ex_ALUop), 0);
        chk("mid_rst_illegal_seen", 32'(illegal_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
